perceptron_trainer: RTL and testbench
=====================================

// Module: perceptron_trainer
// PURPOSE
//   Drives the weight-load side of the 2-input perceptron with the perceptron learning rule.
//   Pulls labelled samples from a streaming source and presents them to the perceptron
//   inputs. Thresholds the returned weighted sum and writes corrected weights back.
//   Repeats epochs until one epoch has zero errors or max_epochs is reached.
// PARAMETERS
//   fp_integer_width  4   integer bits of signed fixed-point word (Q4.12 default)
//   fp_fract_width    12  fractional bits
//   lr_shift          3   learning rate = 2^-lr_shift (delta = x >>> lr_shift)
//   max_epochs        64  epoch limit before giving up (>=1)
//   cnt_width         8   width of epoch_count / error_count
// PORTS  (W = fp_integer_width+fp_fract_width)
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   synchronous active-low reset
//   start          in   1   one-cycle request to begin training; honoured only in IDLE/DONE
//   init_w1        in   W   initial weight1, loaded at start
//   init_w2        in   W   initial weight2, loaded at start
//   sample_valid   in   1   sample source has a sample
//   sample_ready   out  1   trainer accepts a sample (high only in FETCH)
//   sample_x1      in   W   sample input 1
//   sample_x2      in   W   sample input 2
//   sample_target  in   1   desired class (1 = weighted sum >= 0)
//   sample_last    in   1   marks final sample of an epoch
//   epoch_start    out  1   one-cycle pulse: source must rewind to first sample
//   p_in1          out  W   to perceptron IN1 (registered)
//   p_in2          out  W   to perceptron IN2 (registered)
//   p_weight1      in   W   current weight1 from perceptron
//   p_weight2      in   W   current weight2 from perceptron
//   p_result       in   W   weighted sum from perceptron (combinational from p_in*, weights)
//   p_weight1_new  out  W   to perceptron weight1_new (registered)
//   p_weight2_new  out  W   to perceptron weight2_new (registered)
//   p_weight1_ld   out  1   to perceptron weight1_ld
//   p_weight2_ld   out  1   to perceptron weight2_ld
//   busy           out  1   high in any state except IDLE/DONE
//   done           out  1   level; set on entering DONE, cleared on accepted start
//   converged      out  1   valid while done: 1 = last epoch error-free
//   epoch_count    out  cnt_width  epochs completed in current run
//   error_count    out  cnt_width  misclassifications so far in current epoch (saturating)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge, any state): state=IDLE; all outputs 0. Perceptron weights not touched.
//   States: IDLE, INIT, FETCH, EVAL, UPDATE, CHECK, DONE.
//   IDLE/DONE: start -> INIT (done, converged, counters cleared). start while busy is ignored.
//   INIT (1 cyc): p_weight*_new=init_w*, both ld=1; epoch_count=0, error_count=0; epoch_start=1 -> FETCH.
//   FETCH: sample_ready=1; on valid&ready latch x1,x2,target,last into p_in*/regs -> EVAL. No timeout.
//   EVAL (1 cyc): class = ~p_result[W-1]. err=+1 if target&~class; -1 if ~target&class; else 0.
//     err!=0: p_weight*_new = sat(p_weight* +/- (p_in* >>> lr_shift)); error_count+=1 (sat) -> UPDATE.
//     err==0: -> last ? CHECK : FETCH.
//   UPDATE (1 cyc): both ld=1 -> last ? CHECK : FETCH. ld is 0 in every other state except INIT.
//   CHECK (1 cyc): epoch_count+=1.
//     error_count==0 -> DONE, converged=1.
//     else if epoch_count+1==max_epochs -> DONE, converged=0.
//     else error_count=0, epoch_start=1 -> FETCH.
//   Arithmetic: sum in W+1 bits, clamp to [-2^(W-1), 2^(W-1)-1]. Shift is arithmetic (floor).
//   Per sample: 2 cycles if correct (FETCH+EVAL, zero-wait source), 3 if updated.
//   sample_valid outside FETCH is ignored; p_in* hold last sample outside FETCH.
// STRUCTURE
//   Shared header perceptron_pkg.vh: fp widths, Q-format constants (ONE=1<<fract), FSM state encodings.
//   Sub-module fp_sat_addsub (w, x, sub, lr_shift -> saturated w +/- x>>>lr_shift).
//   Two instances, one per weight. FSM and counters stay in this module.
// TESTING  (Q4.12, defaults unless noted; bench instantiates real perceptron)
//   1 Reset: rst_n=0 one edge from any state -> busy=done=ld=sample_ready=epoch_start=0, counts 0.
//   2 Converge: init 0,0; A=(0x1000,0,t=1), B=(0xF000,0,t=0,last).
//     Epoch0: B wrong, w1->0x0200. Epoch1 clean. Result done=1, converged=1, epoch_count=2, w=(0x0200,0).
//   3 Saturation: init (0x7F00,0x8000); sample (0x1000,0x1000,t=1,last).
//     Sum 0xFF00 -> err +1. Result p_weight1_new=0x7FFF, p_weight2_new=0x8200, ld pulse exactly 1 cycle.
//   4 No convergence, max_epochs=4: (0x1000,0,t=1),(0x1000,0,t=0,last).
//     Result done=1, converged=0, epoch_count=4, four epoch_start pulses.
//   5 Handshake: valid low 5 cycles in FETCH -> sample_ready held 1, no ld, state held.
//     start pulsed while busy -> ignored.
//   6 Reset mid-run: rst_n=0 during UPDATE -> next edge ld=0, IDLE.
//     New start runs cleanly from INIT.

Source files
------------

// File: rtl/perceptron_trainer_pkg.sv
// Shared fixed-point defaults and trainer FSM encoding.
// Used by the trainer, its saturating weight-update datapath, and the bench.
package perceptron_trainer_pkg;
  localparam int FP_INT_W_DEF   = 4;
  localparam int FP_FRACT_W_DEF = 12;
  localparam int FP_ONE         = 1 << FP_FRACT_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_EVAL,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_t;
endpackage

// File: rtl/perceptron_trainer_fp_sat_addsub.sv
// Saturating w +/- (x >>> lr_shift) in signed fixed point; purely combinational.
// Zero latency; no flow control.
module perceptron_trainer_fp_sat_addsub #(
  parameter int width    = 16,
  parameter int lr_shift = 3
) (
  input  logic [width-1:0] w,
  input  logic [width-1:0] x,
  input  logic             sub,
  output logic [width-1:0] result
);
  logic signed [width-1:0] delta;
  logic signed [width:0]   sum;

  assign delta = $signed(x) >>> lr_shift;

  always_comb begin
    if (sub) begin
      sum = $signed({w[width-1], w}) - $signed({delta[width-1], delta});
    end else begin
      sum = $signed({w[width-1], w}) + $signed({delta[width-1], delta});
    end
    // The extra sign bit disagreeing with the top data bit means overflow.
    if (sum[width] != sum[width-1]) begin
      result = sum[width] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
    end else begin
      result = sum[width-1:0];
    end
  end
endmodule

// File: rtl/perceptron_trainer.sv
// Trains a 2-input perceptron with the perceptron rule over a rewindable sample stream.
// 2 cycles per correct sample, 3 per corrected one; stalls in FETCH until sample_valid.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int fp_integer_width = FP_INT_W_DEF,
  parameter int fp_fract_width   = FP_FRACT_W_DEF,
  parameter int lr_shift         = 3,
  parameter int max_epochs       = 64,
  parameter int cnt_width        = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [fp_integer_width+fp_fract_width-1:0] init_w1,
  input  logic [fp_integer_width+fp_fract_width-1:0] init_w2,
  input  logic                                       sample_valid,
  output logic                                       sample_ready,
  input  logic [fp_integer_width+fp_fract_width-1:0] sample_x1,
  input  logic [fp_integer_width+fp_fract_width-1:0] sample_x2,
  input  logic                                       sample_target,
  input  logic                                       sample_last,
  output logic                                       epoch_start,
  output logic [fp_integer_width+fp_fract_width-1:0] p_in1,
  output logic [fp_integer_width+fp_fract_width-1:0] p_in2,
  input  logic [fp_integer_width+fp_fract_width-1:0] p_weight1,
  input  logic [fp_integer_width+fp_fract_width-1:0] p_weight2,
  input  logic [fp_integer_width+fp_fract_width-1:0] p_result,
  output logic [fp_integer_width+fp_fract_width-1:0] p_weight1_new,
  output logic [fp_integer_width+fp_fract_width-1:0] p_weight2_new,
  output logic                                       p_weight1_ld,
  output logic                                       p_weight2_ld,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       converged,
  output logic [cnt_width-1:0]                       epoch_count,
  output logic [cnt_width-1:0]                       error_count
);
  localparam int W   = fp_integer_width + fp_fract_width;
  localparam int CW1 = cnt_width + 1;
  localparam logic [CW1-1:0] epoch_limit = CW1'(max_epochs);

  state_t         state;
  logic           target_q;
  logic           last_q;
  logic           cls;
  logic           wrong;
  logic [W-1:0]   w1_upd;
  logic [W-1:0]   w2_upd;
  logic [CW1-1:0] epoch_next;

  assign cls        = ($signed(p_result) >= 0);
  assign wrong      = target_q ^ cls;
  assign epoch_next = {1'b0, epoch_count} + CW1'(1);

  // Target 1 misclassified as 0 pulls weights toward x, target 0 pushes away.
  perceptron_trainer_fp_sat_addsub #(.width(W), .lr_shift(lr_shift)) u_upd_w1 (
    .w      (p_weight1),
    .x      (p_in1),
    .sub    (~target_q),
    .result (w1_upd)
  );

  perceptron_trainer_fp_sat_addsub #(.width(W), .lr_shift(lr_shift)) u_upd_w2 (
    .w      (p_weight2),
    .x      (p_in2),
    .sub    (~target_q),
    .result (w2_upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      target_q      <= 1'b0;
      last_q        <= 1'b0;
      sample_ready  <= 1'b0;
      epoch_start   <= 1'b0;
      p_in1         <= '0;
      p_in2         <= '0;
      p_weight1_new <= '0;
      p_weight2_new <= '0;
      p_weight1_ld  <= 1'b0;
      p_weight2_ld  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      epoch_count   <= '0;
      error_count   <= '0;
    end else begin
      p_weight1_ld <= 1'b0;
      p_weight2_ld <= 1'b0;
      epoch_start  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_INIT;
            busy          <= 1'b1;
            done          <= 1'b0;
            converged     <= 1'b0;
            epoch_count   <= '0;
            error_count   <= '0;
            p_weight1_new <= init_w1;
            p_weight2_new <= init_w2;
            p_weight1_ld  <= 1'b1;
            p_weight2_ld  <= 1'b1;
            epoch_start   <= 1'b1;
          end
        end
        S_INIT: begin
          state        <= S_FETCH;
          sample_ready <= 1'b1;
        end
        S_FETCH: begin
          if (sample_valid) begin
            state        <= S_EVAL;
            sample_ready <= 1'b0;
            p_in1        <= sample_x1;
            p_in2        <= sample_x2;
            target_q     <= sample_target;
            last_q       <= sample_last;
          end
        end
        S_EVAL: begin
          if (wrong) begin
            state         <= S_UPDATE;
            p_weight1_new <= w1_upd;
            p_weight2_new <= w2_upd;
            p_weight1_ld  <= 1'b1;
            p_weight2_ld  <= 1'b1;
            if (error_count != '1) begin
              error_count <= error_count + cnt_width'(1);
            end
          end else if (last_q) begin
            state <= S_CHECK;
          end else begin
            state        <= S_FETCH;
            sample_ready <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (last_q) begin
            state <= S_CHECK;
          end else begin
            state        <= S_FETCH;
            sample_ready <= 1'b1;
          end
        end
        S_CHECK: begin
          epoch_count <= epoch_next[cnt_width-1:0];
          if (error_count == '0) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (epoch_next == epoch_limit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= S_FETCH;
            sample_ready <= 1'b1;
            error_count  <= '0;
            epoch_start  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench: behavioural perceptron + rewindable sample source, queue scoreboard against
// an epoch-level model of the perceptron learning rule.
module tb_perceptron_trainer;
  import perceptron_trainer_pkg::*;

  localparam int MAXE = 4;

  typedef struct {int w1; int w2;} ld_t;
  typedef struct {bit conv; int ep; int errc; int es;} fin_t;

  logic clk = 1'b0;
  logic rst_n, start, sample_valid, sample_ready, sample_target, sample_last, epoch_start;
  logic signed [15:0] init_w1, init_w2, sample_x1, sample_x2, p_in1, p_in2;
  logic signed [15:0] p_result, p_weight1_new, p_weight2_new;
  logic signed [15:0] pw1 = '0;
  logic signed [15:0] pw2 = '0;
  logic p_weight1_ld, p_weight2_ld, busy, done, converged;
  logic [7:0] epoch_count, error_count;

  int checks = 0;
  int errors = 0;
  int sx1[8];
  int sx2[8];
  bit st[8];
  int n_samp = 1;
  int src_idx = 0;
  int stall_pct = 0;
  bit stall = 0;
  bit mon_en = 0;
  int es_count = 0;
  ld_t  exp_ld[$];
  fin_t exp_fin[$];

  always #5 clk = ~clk;

  perceptron_trainer #(.max_epochs(MAXE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_w1(init_w1), .init_w2(init_w2),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_x1(sample_x1),
    .sample_x2(sample_x2), .sample_target(sample_target), .sample_last(sample_last),
    .epoch_start(epoch_start), .p_in1(p_in1), .p_in2(p_in2), .p_weight1(pw1),
    .p_weight2(pw2), .p_result(p_result), .p_weight1_new(p_weight1_new),
    .p_weight2_new(p_weight2_new), .p_weight1_ld(p_weight1_ld), .p_weight2_ld(p_weight2_ld),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
    .error_count(error_count)
  );

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int psum(input int a1, input int b1, input int a2, input int b2);
    longint p;
    p = longint'(a1) * longint'(b1) + longint'(a2) * longint'(b2);
    return sat16(p >>> 12);
  endfunction

  // Behavioural perceptron: weight registers plus combinational Q4.12 dot product.
  always @(posedge clk) begin
    if (p_weight1_ld) pw1 <= p_weight1_new;
    if (p_weight2_ld) pw2 <= p_weight2_new;
  end
  assign p_result = 16'(psum(int'(pw1), int'(p_in1), int'(pw2), int'(p_in2)));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole epochs of the perceptron rule on plain integers.
  task automatic build_model(input int i1, input int i2);
    int w1, w2, errs, epochs, s, d1, d2;
    bit conv;
    ld_t l;
    fin_t f;
    w1 = i1; w2 = i2; errs = 0; epochs = 0; conv = 0;
    l.w1 = w1; l.w2 = w2;
    exp_ld.push_back(l);
    while (epochs < MAXE && !conv) begin
      errs = 0;
      for (int i = 0; i < n_samp; i++) begin
        s = psum(w1, sx1[i], w2, sx2[i]);
        if ((s >= 0) != st[i]) begin
          d1 = sx1[i] >>> 3;
          d2 = sx2[i] >>> 3;
          w1 = st[i] ? sat16(longint'(w1 + d1)) : sat16(longint'(w1 - d1));
          w2 = st[i] ? sat16(longint'(w2 + d2)) : sat16(longint'(w2 - d2));
          errs++;
          l.w1 = w1; l.w2 = w2;
          exp_ld.push_back(l);
        end
      end
      epochs++;
      conv = (errs == 0);
    end
    f.conv = conv; f.ep = epochs; f.errc = (errs > 255) ? 255 : errs; f.es = epochs;
    exp_fin.push_back(f);
  endtask

  // Sample source: advances on handshake, wraps after last, rewinds on epoch_start.
  initial begin : source
    bit hs, es;
    sample_valid = 0; sample_x1 = '0; sample_x2 = '0; sample_target = 0; sample_last = 0;
    forever begin
      @(posedge clk);
      hs = sample_valid && sample_ready;
      es = epoch_start;
      @(negedge clk);
      if (!rst_n) src_idx = 0;
      else if (hs) src_idx = sample_last ? 0 : src_idx + 1;
      else if (es) src_idx = 0;
      if (src_idx >= n_samp) src_idx = 0;
      sample_valid  = !stall && (int'($urandom_range(0, 99)) >= stall_pct);
      sample_x1     = 16'(sx1[src_idx]);
      sample_x2     = 16'(sx2[src_idx]);
      sample_target = st[src_idx];
      sample_last   = (src_idx == n_samp - 1);
    end
  end

  initial begin : monitor
    bit ld_prev, done_prev;
    ld_t l;
    fin_t f;
    ld_prev = 0; done_prev = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (epoch_start) es_count++;
        if (p_weight1_ld || p_weight2_ld) begin
          chk("ld_single_cycle", int'(ld_prev), 0);
          chk("ld_both", int'({p_weight1_ld, p_weight2_ld}), 3);
          chk("ld_expected", int'(exp_ld.size() > 0), 1);
          if (exp_ld.size() > 0) begin
            l = exp_ld.pop_front();
            chk("weight1_new", int'(p_weight1_new), l.w1);
            chk("weight2_new", int'(p_weight2_new), l.w2);
          end
        end
        if (done && !done_prev) begin
          chk("done_expected", int'(exp_fin.size() > 0), 1);
          if (exp_fin.size() > 0) begin
            f = exp_fin.pop_front();
            chk("converged", int'(converged), int'(f.conv));
            chk("epoch_count", int'(epoch_count), f.ep);
            chk("error_count", int'(error_count), f.errc);
            chk("epoch_start_pulses", es_count, f.es);
            chk("ld_leftover", exp_ld.size(), 0);
            chk("busy_at_done", int'(busy), 0);
          end
        end
      end
      ld_prev = p_weight1_ld || p_weight2_ld;
      done_prev = done;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int i1, input int i2);
    es_count = 0;
    init_w1 = 16'(i1);
    init_w2 = 16'(i2);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_train(input int i1, input int i2);
    build_model(i1, i2);
    pulse_start(i1, i2);
    wait_done();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ld"}, int'({p_weight1_ld, p_weight2_ld}), 0);
    chk({tag, "_ready"}, int'(sample_ready), 0);
    chk({tag, "_epoch_start"}, int'(epoch_start), 0);
    chk({tag, "_epoch_count"}, int'(epoch_count), 0);
    chk({tag, "_error_count"}, int'(error_count), 0);
    chk({tag, "_converged"}, int'(converged), 0);
  endtask

  task automatic set_sample(input int i, input int x1, input int x2, input bit t);
    sx1[i] = x1; sx2[i] = x2; st[i] = t;
  endtask

  initial begin : main
    int n;
    rst_n = 0; start = 0; init_w1 = '0; init_w2 = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_p_in1", int'(p_in1), 0);
    chk("reset_w1_new", int'(p_weight1_new), 0);
    rst_n = 1;
    mon_en = 1;
    @(negedge clk);

    // Separable pair: one correction then a clean epoch.
    n_samp = 2;
    set_sample(0, FP_ONE, 0, 1);
    set_sample(1, -FP_ONE, 0, 0);
    run_train(0, 0);
    chk("conv_w1", int'(pw1), 512);
    chk("conv_w2", int'(pw2), 0);
    chk("conv_epochs", int'(epoch_count), 2);

    // Update that clamps weight1 at the positive limit.
    n_samp = 1;
    set_sample(0, FP_ONE, FP_ONE, 1);
    run_train(32512, -32768);
    chk("sat_w1", int'(pw1), 32767);
    chk("sat_w2", int'(pw2), -32256);

    // Contradictory samples never converge.
    n_samp = 2;
    set_sample(0, FP_ONE, 0, 1);
    set_sample(1, FP_ONE, 0, 0);
    run_train(0, 0);
    chk("noconv_converged", int'(converged), 0);
    chk("noconv_epochs", int'(epoch_count), MAXE);

    // Source stalls in FETCH; a start while busy must be ignored.
    n_samp = 2;
    set_sample(0, FP_ONE, 0, 1);
    set_sample(1, -FP_ONE, 0, 0);
    stall = 1;
    build_model(0, 0);
    pulse_start(0, 0);
    n = 0;
    while (!sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", int'(sample_ready), 1);
      chk("stall_ld", int'(p_weight1_ld), 0);
      start = (c == 1);
      @(negedge clk);
    end
    start = 0;
    chk("stall_busy", int'(busy), 1);
    stall = 0;
    wait_done();

    // Reset while an update is being written back.
    n_samp = 2;
    set_sample(0, FP_ONE, 0, 1);
    set_sample(1, FP_ONE, 0, 0);
    build_model(0, 0);
    pulse_start(0, 0);
    n = 0;
    while (!(p_weight1_ld && !epoch_start) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_update_seen", int'(p_weight1_ld), 1);
    mon_en = 0;
    rst_n = 0;
    @(negedge clk);
    check_idle("midrun_reset");
    rst_n = 1;
    exp_ld.delete();
    exp_fin.delete();
    @(negedge clk);
    mon_en = 1;
    run_train(-1024, 2048);

    // Randomised sample sets, weights and source stalls.
    for (int r = 0; r < 12; r++) begin
      n_samp = int'($urandom_range(1, 6));
      for (int i = 0; i < n_samp; i++) begin
        set_sample(i, int'($urandom_range(0, 16'h3000)) - 16'h1800,
                   int'($urandom_range(0, 16'h3000)) - 16'h1800, 1'($urandom_range(0, 1)));
      end
      stall_pct = int'($urandom_range(0, 50));
      run_train(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
